// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bus of the scoreboarded register file.
// master = pipeline driving addresses and write data, slave = register file.
interface reg_file_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic              rd_busy_1;
  logic              rd_busy_2;
  logic [1:0]        rd_en;
  logic              stall;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rd_addr_1, rd_addr_2, rd_en, issue_en, issue_addr, wr_en, wr_addr, wr_data,
    input  rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, stall, busy_cnt
  );

  modport slave (
    input  rd_addr_1, rd_addr_2, rd_en, issue_en, issue_addr, wr_en, wr_addr, wr_data,
    output rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, stall, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file (r0 = 0) with busy-bit scoreboard and registered busy count.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy to the read ports.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input logic           clk,
  input logic           rst,
  reg_file_sb_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_REGS - 1);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busyQ;
  logic [CNT_W-1:0]    busyCnt;

  logic             wrOk, issueOk, rd1Ok, rd2Ok;
  logic [IDX_W-1:0] wrIdx, issueIdx, rd1Idx, rd2Idx;
  logic             cntInc, cntDec;
  logic [DATA_W-1:0] rdData1, rdData2;
  logic             rdBusy1, rdBusy2;

  // r0 and anything past NUM_REGS behave as an always-zero, never-busy register
  function automatic logic addrOk(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  always_comb begin
    wrOk     = bus.wr_en && addrOk(bus.wr_addr);
    issueOk  = bus.issue_en && addrOk(bus.issue_addr);
    rd1Ok    = addrOk(bus.rd_addr_1);
    rd2Ok    = addrOk(bus.rd_addr_2);
    wrIdx    = IDX_W'(bus.wr_addr);
    issueIdx = IDX_W'(bus.issue_addr);
    rd1Idx   = IDX_W'(bus.rd_addr_1);
    rd2Idx   = IDX_W'(bus.rd_addr_2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wrOk) begin
      regs[wrIdx] <= bus.wr_data;
    end
  end

  // issue is applied after the write clear so a same-address issue wins
  always_ff @(posedge clk) begin
    if (rst) begin
      busyQ <= '0;
    end else begin
      if (wrOk)    busyQ[wrIdx]    <= 1'b0;
      if (issueOk) busyQ[issueIdx] <= 1'b1;
    end
  end

  always_comb begin
    cntInc = issueOk && !busyQ[issueIdx];
    cntDec = wrOk && busyQ[wrIdx] && !(issueOk && (bus.issue_addr == bus.wr_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busyCnt <= '0;
    end else if (cntInc && !cntDec && (busyCnt != CNT_MAX)) begin
      busyCnt <= busyCnt + CNT_W'(1);
    end else if (cntDec && !cntInc && (busyCnt != '0)) begin
      busyCnt <= busyCnt - CNT_W'(1);
    end
  end

  always_comb begin
    rdData1 = '0;
    rdBusy1 = 1'b0;
    if (rd1Ok) begin
      rdData1 = regs[rd1Idx];
      rdBusy1 = busyQ[rd1Idx];
`ifdef REGFILE_BYPASS_EN
      if (wrOk && (bus.wr_addr == bus.rd_addr_1)) begin
        rdData1 = bus.wr_data;
        if (!(issueOk && (bus.issue_addr == bus.rd_addr_1))) rdBusy1 = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rdData2 = '0;
    rdBusy2 = 1'b0;
    if (rd2Ok) begin
      rdData2 = regs[rd2Idx];
      rdBusy2 = busyQ[rd2Idx];
`ifdef REGFILE_BYPASS_EN
      if (wrOk && (bus.wr_addr == bus.rd_addr_2)) begin
        rdData2 = bus.wr_data;
        if (!(issueOk && (bus.issue_addr == bus.rd_addr_2))) rdBusy2 = 1'b0;
      end
`endif
    end
  end

  assign bus.rd_data_1 = rdData1;
  assign bus.rd_data_2 = rdData2;
  assign bus.rd_busy_1 = rdBusy1;
  assign bus.rd_busy_2 = rdBusy2;
  assign bus.stall     = (bus.rd_en[0] && rdBusy1) || (bus.rd_en[1] && rdBusy2);
  assign bus.busy_cnt  = busyCnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default 5-bit instance plus a 6-bit-address
// instance for out-of-range accesses.
module tb_reg_file_sb;
  logic clk;
  logic rst;
  int   totalChecks = 0;
  int   badChecks   = 0;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(6)) busW ();

  reg_file_sb #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  reg_file_sb #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(6)) dutW (
    .clk (clk),
    .rst (rst),
    .bus (busW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_addr_1 = '0; bus.rd_addr_2 = '0; bus.rd_en = 2'b00;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    busW.rd_addr_1 = '0; busW.rd_addr_2 = '0; busW.rd_en = 2'b00;
    busW.issue_en = 1'b0; busW.issue_addr = '0;
    busW.wr_en = 1'b0; busW.wr_addr = '0; busW.wr_data = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    bus.rd_addr_1 = 5'd2; bus.rd_addr_2 = 5'd7; bus.rd_en = 2'b11;
    settle();
    check("rst_data1", bus.rd_data_1, 0);
    check("rst_data2", bus.rd_data_2, 0);
    check("rst_busy1", bus.rd_busy_1, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_cnt", bus.busy_cnt, 0);
    bus.rd_en = 2'b00;

    // plain write, visible on both ports next cycle
    bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'd5;
    tick();
    bus.wr_en = 1'b0; bus.rd_addr_1 = 5'd2; bus.rd_addr_2 = 5'd2;
    settle();
    check("r2_port1", bus.rd_data_1, 5);
    check("r2_port2", bus.rd_data_2, 5);
    check("init_write_cnt", bus.busy_cnt, 0);

    // r0 ignores writes
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF;
    tick();
    bus.wr_en = 1'b0; bus.rd_addr_1 = 5'd0;
    settle();
    check("r0_zero", bus.rd_data_1, 0);

    // issue r6, stall on port 1
    bus.issue_en = 1'b1; bus.issue_addr = 5'd6;
    tick();
    bus.issue_en = 1'b0; bus.rd_en = 2'b01; bus.rd_addr_1 = 5'd6;
    settle();
    check("r6_busy", bus.rd_busy_1, 1);
    check("r6_stall", bus.stall, 1);
    check("r6_cnt", bus.busy_cnt, 1);
    bus.rd_en = 2'b00;
    settle();
    check("stall_masked", bus.stall, 0);
    bus.rd_en = 2'b01;

    // writeback clears
    bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'd15;
    tick();
    bus.wr_en = 1'b0;
    settle();
    check("r6_wb_stall", bus.stall, 0);
    check("r6_wb_data", bus.rd_data_1, 15);
    check("r6_wb_cnt", bus.busy_cnt, 0);

    // same-cycle issue+write on a busy register
    bus.issue_en = 1'b1; bus.issue_addr = 5'd6;
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'd16;
    tick();
    bus.issue_en = 1'b0; bus.wr_en = 1'b0;
    settle();
    check("iw_data", bus.rd_data_1, 16);
    check("iw_busy", bus.rd_busy_1, 1);
    check("iw_cnt", bus.busy_cnt, 1);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'd17;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 2'b00;
    settle();
    check("r6_clear_cnt", bus.busy_cnt, 0);

    // write-to-read overlap on port 2
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hAA;
    tick();
    bus.wr_en = 1'b0; bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
    tick();
    bus.issue_en = 1'b0; bus.rd_addr_2 = 5'd3; bus.rd_en = 2'b10;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h1234;
    settle();
`ifdef REGFILE_BYPASS_EN
    check("byp_data", bus.rd_data_2, 32'h1234);
    check("byp_stall", bus.stall, 0);
`else
    check("nobyp_data", bus.rd_data_2, 32'hAA);
    check("nobyp_stall", bus.stall, 1);
`endif
    tick();
    bus.wr_en = 1'b0;
    settle();
    check("r3_after_data", bus.rd_data_2, 32'h1234);
    check("r3_after_stall", bus.stall, 0);
    check("r3_after_cnt", bus.busy_cnt, 0);
    bus.rd_en = 2'b00;

    // fill the scoreboard
    bus.issue_en = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.issue_addr = 5'(i);
      tick();
    end
    bus.issue_en = 1'b0;
    check("full_cnt", bus.busy_cnt, 31);
    bus.issue_en = 1'b1; bus.issue_addr = 5'd5;
    tick();
    check("reissue_cnt", bus.busy_cnt, 31);
    bus.issue_addr = 5'd0;
    tick();
    bus.issue_en = 1'b0;
    check("issue_r0_cnt", bus.busy_cnt, 31);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'd1;
    tick();
    bus.wr_en = 1'b0;
    check("dec_cnt", bus.busy_cnt, 30);

    // reset dominates a concurrent write
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h55;
    tick();
    rst = 1'b0; bus.wr_en = 1'b0;
    bus.rd_addr_1 = 5'd7; bus.rd_addr_2 = 5'd2; bus.rd_en = 2'b11;
    settle();
    check("post_rst_cnt", bus.busy_cnt, 0);
    check("post_rst_r7", bus.rd_data_1, 0);
    check("post_rst_r2", bus.rd_data_2, 0);
    check("post_rst_stall", bus.stall, 0);

    // out-of-range accesses on the 6-bit-address instance
    busW.wr_en = 1'b1; busW.wr_addr = 6'd40; busW.wr_data = 32'd7;
    busW.issue_en = 1'b1; busW.issue_addr = 6'd40;
    tick();
    busW.wr_en = 1'b0; busW.issue_en = 1'b0;
    busW.rd_addr_1 = 6'd40; busW.rd_addr_2 = 6'd32; busW.rd_en = 2'b11;
    settle();
    check("oor_data", busW.rd_data_1, 0);
    check("oor_busy", busW.rd_busy_1, 0);
    check("oor32_data", busW.rd_data_2, 0);
    check("oor_cnt", busW.busy_cnt, 0);
    check("oor_stall", busW.stall, 0);
    busW.wr_en = 1'b1; busW.wr_addr = 6'd31; busW.wr_data = 32'd9;
    tick();
    busW.wr_en = 1'b0; busW.rd_addr_1 = 6'd31;
    settle();
    check("wide_r31", busW.rd_data_1, 9);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file with an integrated busy-bit scoreboard for multi-cycle producers. It has two asynchronous read ports, one synchronous write port, and one issue port that marks a destination register pending. It sits between decode and execute: decode reads operands and checks stall; writeback writes results and clears the pending state. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `NUM_REGS`, 32, number of registers; must be ≤ 2^`ADDR_W`
- `ADDR_W`, 5, register address width

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rd_addr_1`  in  `ADDR_W`  read port 1 address
- `rd_addr_2`  in  `ADDR_W`  read port 2 address
- `rd_data_1`  out  `DATA_W`  read port 1 data (combinational)
- `rd_data_2`  out  `DATA_W`  read port 2 data (combinational)
- `rd_busy_1`  out  1  register at `rd_addr_1` has a pending write
- `rd_busy_2`  out  1  register at `rd_addr_2` has a pending write
- `rd_en`  in  2  bit k: port k+1 operand is actually used this cycle
- `stall`  out  1  = (`rd_en[0]` & `rd_busy_1`) | (`rd_en[1]` & `rd_busy_2`)
- `issue_en`  in  1  mark `issue_addr` busy at next edge
- `issue_addr`  in  `ADDR_W`  destination being issued
- `wr_en`  in  1  write `wr_data` to `wr_addr` at next edge and clear its busy bit
- `wr_addr`  in  `ADDR_W`  write address
- `wr_data`  in  `DATA_W`  write data
- `busy_cnt`  out  `ADDR_W`+1  number of registers currently busy (registered)

## Operation
- Storage: `NUM_REGS` x `DATA_W` flops plus `busy_q[NUM_REGS-1:0]`.
- Reads: `rd_data_k` = `regs[rd_addr_k]`; address 0 or address ≥ `NUM_REGS` returns 0 and busy 0.
- Write: on edge with `wr_en`, `regs[wr_addr]` ← `wr_data`, `busy_q[wr_addr]` ← 0. Writes to 0 or out-of-range addresses are ignored.
- Issue: on edge with `issue_en`, `busy_q[issue_addr]` ← 1. Issue to 0 or out-of-range is ignored.
- Same-address issue and write in one cycle: data is written, and busy ends up 1 (the new issue wins).
- `busy_cnt`: +1 for an effective issue setting a clear bit; -1 for an effective write clearing a set bit; net 0 for same-address issue+write on a busy bit. Re-issuing an already-busy register does not increment. Writing a non-busy register is legal (initialisation) and does not decrement. Never wraps: max `NUM_REGS`-1, min 0.
- Reset: all registers = 0, `busy_q` = 0, `busy_cnt` = 0. Reset dominates `issue_en`/`wr_en` in the same cycle; a pending write mid-flight is simply lost.

## Timing
- Read latency 0 (combinational from address and state). Write/issue take effect at the next rising edge.
- Reset values: `rd_data_*` = 0, `rd_busy_*` = 0, `stall` = 0, `busy_cnt` = 0.
- `stall` is combinational; decode must hold its instruction while `stall` = 1. `issue_en` is not gated internally by `stall`; upstream must not assert it while stalled.

## Configuration
- `REGFILE_BYPASS_EN` defined: on a write-to-read match (`wr_en`, `wr_addr` == `rd_addr_k` ≠ 0, in range), `rd_data_k` = `wr_data` in the same cycle, and `rd_busy_k` is forced to 0 unless `issue_en` targets the same address that cycle. `stall` uses the bypassed busy.
- Not defined: reads see stored values only; a written value is visible the cycle after the write; `rd_busy_k` = `busy_q[rd_addr_k]`.

## Test plan
- Reset, then write 5 to r2 with `wr_en`. Next cycle read r2 → 5 on both ports; read r0 after a write of 0xFFFF to r0 → 0.
- Issue r6 with `rd_en`=01 and `rd_addr_1`=6 → next cycle `rd_busy_1`=1, `stall`=1, `busy_cnt`=1. Write 15 to r6 → following cycle `stall`=0, `rd_data_1`=15, `busy_cnt`=0.
- Issue r6 and write 16 to r6 in the same cycle while r6 is busy → r6=16, busy stays 1, `busy_cnt` unchanged.
- With `REGFILE_BYPASS_EN`: r3 busy, drive `wr_en` r3=0x1234 with `rd_addr_2`=3, `rd_en`=10 → same cycle `rd_data_2`=0x1234, `stall`=0. Without the macro: `rd_data_2` shows the old value and `stall`=1 for that cycle.
- Issue r1..r31 over consecutive cycles → `busy_cnt`=31. Re-issue r5 → `busy_cnt` stays 31. Assert `rst` → next cycle all regs 0 and `busy_cnt`=0.
- Write 7 to address 40 with `NUM_REGS`=32, `ADDR_W`=6 → no state change; a read of 40 returns 0 with busy 0.
